// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage pipeline: resolves load-use, branch-in-ID and
// data-memory wait hazards, and keeps saturating stall/flush statistics plus a stall watchdog.
module hazard_stall_unit #(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned MAX_STALL = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IFID_src1,
  input  logic [4:0]       IFID_src2,
  input  logic             ID_usesSrc2,
  input  logic             ID_branch,
  input  logic             ID_branchTaken,
  input  logic             IDEX_MemRead,
  input  logic             IDEX_RegWrite,
  input  logic [4:0]       IDEX_dest,
  input  logic             EXMEM_MemRead,
  input  logic [4:0]       EXMEM_dest,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IDEXWrite,
  output logic             EXMEM_hold,
  output logic             IFID_flush,
  output logic             IDEX_flush,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             stall_err
);

  localparam int unsigned RUN_W = 8;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_HAZ      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  state_t           state_q;
  state_t           cls;
  logic             match_ex;
  logic             match_mem;
  logic             mem_wait;
  logic             load_use;
  logic             br_ex;
  logic             br_mem;
  logic             haz;
  logic [RUN_W-1:0] run;

  // Dependency of the ID instruction on the EX / MEM destinations; r0 never matches
  always_comb begin
    match_ex  = (IDEX_dest != 5'd0) &&
                ((IDEX_dest == IFID_src1) || (ID_usesSrc2 && (IDEX_dest == IFID_src2)));
    match_mem = (EXMEM_dest != 5'd0) &&
                ((EXMEM_dest == IFID_src1) || (ID_usesSrc2 && (EXMEM_dest == IFID_src2)));
    mem_wait  = dmem_req && !dmem_ready;
    load_use  = IDEX_MemRead && match_ex;
    br_ex     = ID_branch && IDEX_RegWrite && match_ex;
    br_mem    = ID_branch && EXMEM_MemRead && match_mem;
    haz       = load_use || br_ex || br_mem;
  end

  // Cycle classification and combinational pipeline controls
  always_comb begin
    cls        = ST_RUN;
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IDEXWrite  = 1'b1;
    EXMEM_hold = 1'b0;
    IFID_flush = 1'b0;
    IDEX_flush = 1'b0;
    if (rst) begin
      cls = ST_RUN;
    end else if (mem_wait) begin
      cls        = ST_MEM_WAIT;
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXWrite  = 1'b0;
      EXMEM_hold = 1'b1;
    end else if (haz) begin
      cls        = ST_HAZ;
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEX_flush = 1'b1;
    end else begin
      IFID_flush = ID_branch && ID_branchTaken;
    end
  end

  // Status, statistics and watchdog
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
      run       <= '0;
      stall_err <= 1'b0;
    end else begin
      state_q <= cls;
      if (cls != ST_RUN) begin
        if (stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + CNT_W'(1);
        if (run == RUN_W'(MAX_STALL - 1)) stall_err <= 1'b1;
        if (run != {RUN_W{1'b1}}) run <= run + RUN_W'(1);
      end else begin
        run <= '0;
      end
      if (IFID_flush && (flush_cnt != {CNT_W{1'b1}})) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: directed scenarios plus randomized traffic
// compared against a rule-level reference model.
module tb_hazard_stall_unit;

  localparam int unsigned CNT_W     = 4;
  localparam int unsigned MAX_STALL = 8;
  localparam int          CNT_MAX   = 15;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [4:0]       IFID_src1 = '0, IFID_src2 = '0, IDEX_dest = '0, EXMEM_dest = '0;
  logic             ID_usesSrc2 = 0, ID_branch = 0, ID_branchTaken = 0;
  logic             IDEX_MemRead = 0, IDEX_RegWrite = 0, EXMEM_MemRead = 0;
  logic             dmem_req = 0, dmem_ready = 0;
  logic             PCWrite, IFIDWrite, IDEXWrite, EXMEM_hold, IFID_flush, IDEX_flush;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             stall_err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_state = 0, m_stall = 0, m_flush = 0, m_run = 0;
  bit m_err = 0;

  hazard_stall_unit #(.CNT_W(CNT_W), .MAX_STALL(MAX_STALL)) dut (
    .clk(clk), .rst(rst),
    .IFID_src1(IFID_src1), .IFID_src2(IFID_src2), .ID_usesSrc2(ID_usesSrc2),
    .ID_branch(ID_branch), .ID_branchTaken(ID_branchTaken),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_RegWrite(IDEX_RegWrite), .IDEX_dest(IDEX_dest),
    .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_dest(EXMEM_dest),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXWrite(IDEXWrite),
    .EXMEM_hold(EXMEM_hold), .IFID_flush(IFID_flush), .IDEX_flush(IDEX_flush),
    .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .stall_err(stall_err)
  );

  always #5 clk = ~clk;

  wire [5:0]  ctl  = {PCWrite, IFIDWrite, IDEXWrite, EXMEM_hold, IFID_flush, IDEX_flush};
  wire [10:0] stat = {state, stall_cnt, flush_cnt, stall_err};

  function automatic bit dep(input logic [4:0] d);
    return (d != 0) && (d == IFID_src1 || (ID_usesSrc2 && d == IFID_src2));
  endfunction

  // Expected {PCWrite, IFIDWrite, IDEXWrite, EXMEM_hold, IFID_flush, IDEX_flush}
  function automatic logic [5:0] exp_ctl();
    bit hz;
    if (rst) return 6'b111000;
    if (dmem_req && !dmem_ready) return 6'b000100;
    hz = (IDEX_MemRead && dep(IDEX_dest)) ||
         (ID_branch && IDEX_RegWrite && dep(IDEX_dest)) ||
         (ID_branch && EXMEM_MemRead && dep(EXMEM_dest));
    if (hz) return 6'b001001;
    return {4'b1110, ID_branch && ID_branchTaken, 1'b0};
  endfunction

  function automatic logic [10:0] exp_stat();
    return {2'(m_state), 4'(m_stall), 4'(m_flush), m_err};
  endfunction

  // Advance the model by one clock edge using the inputs applied this cycle
  task automatic model_edge();
    logic [5:0] c;
    int cls;
    c = exp_ctl();
    if (rst) begin
      m_state = 0; m_stall = 0; m_flush = 0; m_run = 0; m_err = 0;
      return;
    end
    cls = (c == 6'b000100) ? 2 : (c == 6'b001001) ? 1 : 0;
    m_state = cls;
    if (cls != 0) begin
      if (m_stall < CNT_MAX) m_stall++;
      if (m_run == MAX_STALL - 1) m_err = 1;
      if (m_run < 255) m_run++;
    end else begin
      m_run = 0;
    end
    if (c[1] && m_flush < CNT_MAX) m_flush++;
  endtask

  task automatic clear_in();
    IFID_src1 = 0; IFID_src2 = 0; IDEX_dest = 0; EXMEM_dest = 0;
    ID_usesSrc2 = 0; ID_branch = 0; ID_branchTaken = 0;
    IDEX_MemRead = 0; IDEX_RegWrite = 0; EXMEM_MemRead = 0;
    dmem_req = 0; dmem_ready = 0; rst = 0;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1;
    @(posedge clk); model_edge(); #1;
    rst = 0;
  endtask

  task automatic test_reset();
    clear_in();
    rst = 1; IDEX_MemRead = 1; IDEX_dest = 3; IFID_src1 = 3; dmem_req = 1;
    #1;
    checks++;
    if (ctl !== 6'b111000) begin
      errors++; $display("FAIL reset_ctl got %b want %b", ctl, 6'b111000);
    end
    @(posedge clk); model_edge(); #1;
    checks++;
    if (stat !== 11'd0) begin
      errors++; $display("FAIL reset_stat got %h want %h", stat, 11'd0);
    end
    rst = 0;
  endtask

  task automatic test_load_use();
    bit stall_lit [4] = '{1, 0, 0, 1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      clear_in();
      IDEX_MemRead = 1;
      case (i)
        0: begin IDEX_dest = 8; IFID_src1 = 8; end
        1: begin IDEX_dest = 0; IFID_src1 = 0; end
        2: begin IDEX_dest = 9; IFID_src2 = 9; IFID_src1 = 4; ID_usesSrc2 = 0; end
        default: begin IDEX_dest = 9; IFID_src2 = 9; IFID_src1 = 4; ID_usesSrc2 = 1; end
      endcase
      #1;
      checks++;
      if (ctl !== exp_ctl() || PCWrite !== !stall_lit[i] || IDEX_flush !== stall_lit[i]) begin
        errors++; $display("FAIL load_use_ctl case %0d got %b want %b", i, ctl, exp_ctl());
      end
      @(posedge clk); model_edge(); #1;
      checks++;
      if (stat !== exp_stat() || state !== 2'(stall_lit[i])) begin
        errors++; $display("FAIL load_use_stat case %0d got %h want %h", i, stat, exp_stat());
      end
    end
  endtask

  task automatic test_load_branch();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      clear_in();
      ID_branch = 1; IFID_src1 = 8; IFID_src2 = 2; ID_usesSrc2 = 1;
      if (i == 0) begin IDEX_MemRead = 1; IDEX_RegWrite = 1; IDEX_dest = 8; end
      if (i == 1) begin EXMEM_MemRead = 1; EXMEM_dest = 8; end
      if (i == 2) ID_branchTaken = 1;
      #1;
      checks++;
      if (ctl !== exp_ctl() || IFID_flush !== (i == 2)) begin
        errors++; $display("FAIL load_branch_ctl cyc %0d got %b want %b", i, ctl, exp_ctl());
      end
      @(posedge clk); model_edge(); #1;
      checks++;
      if (stat !== exp_stat()) begin
        errors++; $display("FAIL load_branch_stat cyc %0d got %h want %h", i, stat, exp_stat());
      end
    end
    checks++;
    if (stall_cnt !== 4'd2 || flush_cnt !== 4'd1) begin
      errors++; $display("FAIL load_branch_cnt got %0d/%0d want 2/1", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      clear_in();
      IDEX_MemRead = 1; IDEX_dest = 5; IFID_src1 = 5;
      dmem_req = 1; dmem_ready = (i == 3);
      #1;
      checks++;
      if (ctl !== exp_ctl() || ctl !== ((i == 3) ? 6'b001001 : 6'b000100)) begin
        errors++; $display("FAIL mem_wait_ctl cyc %0d got %b want %b", i, ctl, exp_ctl());
      end
      @(posedge clk); model_edge(); #1;
      checks++;
      if (stat !== exp_stat() || state !== ((i == 3) ? 2'd1 : 2'd2)) begin
        errors++; $display("FAIL mem_wait_stat cyc %0d got %h want %h", i, stat, exp_stat());
      end
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      clear_in();
      dmem_req = (i < 8);
      @(posedge clk); model_edge(); #1;
      checks++;
      if (stat !== exp_stat() || stall_err !== (i >= 7)) begin
        errors++; $display("FAIL watchdog cyc %0d got %h want %h", i, stat, exp_stat());
      end
    end
    do_reset();
    checks++;
    if (stall_err !== 1'b0 || stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
      errors++; $display("FAIL watchdog_rst got err=%b cnt=%0d/%0d want 0 0/0",
                         stall_err, stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      clear_in();
      ID_branch = 1; ID_branchTaken = 1; IFID_src1 = 7;
      @(posedge clk); model_edge(); #1;
    end
    checks++;
    if (flush_cnt !== 4'd15 || stat !== exp_stat()) begin
      errors++; $display("FAIL saturation got flush_cnt=%0d want 15", flush_cnt);
    end
    clear_in();
    dmem_req = 1;
    @(posedge clk); model_edge(); #1;
    rst = 1; IDEX_MemRead = 1; IDEX_dest = 6; IFID_src1 = 6;
    #1;
    checks++;
    if (ctl !== 6'b111000) begin
      errors++; $display("FAIL rst_mid_stall_ctl got %b want %b", ctl, 6'b111000);
    end
    @(posedge clk); model_edge(); #1;
    checks++;
    if (stat !== 11'd0) begin
      errors++; $display("FAIL rst_mid_stall_stat got %h want 0", stat);
    end
    rst = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst            = ($urandom_range(0, 31) == 0);
      IFID_src1      = 5'($urandom_range(0, 3));
      IFID_src2      = 5'($urandom_range(0, 3));
      IDEX_dest      = 5'($urandom_range(0, 3));
      EXMEM_dest     = 5'($urandom_range(0, 3));
      ID_usesSrc2    = 1'($urandom);
      ID_branch      = 1'($urandom);
      ID_branchTaken = 1'($urandom);
      IDEX_MemRead   = 1'($urandom);
      IDEX_RegWrite  = 1'($urandom);
      EXMEM_MemRead  = 1'($urandom);
      dmem_req       = ($urandom_range(0, 3) == 0);
      dmem_ready     = ($urandom_range(0, 2) != 0) && (i % 40 < 25);
      #1;
      checks++;
      if (ctl !== exp_ctl()) begin
        errors++; $display("FAIL random_ctl cyc %0d got %b want %b", i, ctl, exp_ctl());
      end
      @(posedge clk); model_edge(); #1;
      checks++;
      if (stat !== exp_stat()) begin
        errors++; $display("FAIL random_stat cyc %0d got %h want %h", i, stat, exp_stat());
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_load_branch();
    test_mem_wait();
    test_watchdog();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
